// File: rtl/filter_ctrl.sv
// rtl/filter_ctrl.sv - per-sample voice accumulate / filter handshake / mix sequencer
//
// Purpose: on each sample_tick captures three voices and a route mask, sums
// routed voices (filter path) and unrouted voices (bypass path), hands the
// saturated routed sum to the filter over a start/done handshake with timeout,
// and produces one saturated mixed output sample.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   sample_tick                one-cycle frame start pulse
//   voice0..voice2, route      voice samples and filter route mask
//   clr_err                    clears sticky error flags
//   filt_start, filt_in        filter request and input sample
//   filt_done, filt_out        filter result handshake
//   mix_out, mix_valid         mixed sample and its update pulse
//   busy, overrun, timeout_err status and sticky errors
module filter_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic [7:0] voice0,
  input  logic [7:0] voice1,
  input  logic [7:0] voice2,
  input  logic [2:0] route,
  input  logic       clr_err,
  output logic       filt_start,
  output logic [7:0] filt_in,
  input  logic       filt_done,
  input  logic [7:0] filt_out,
  output logic [7:0] mix_out,
  output logic       mix_valid,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, ACC, FILT, MIX} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] v0_q, v1_q, v2_q;
  logic [2:0] route_q;
  logic [9:0] racc, bacc;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [7:0] result;

  logic [7:0] cur_voice;
  logic       cur_route;
  logic [9:0] racc_nxt, bacc_nxt;
  logic [9:0] mix_sum;
  logic       ovr_set, tout_set;

  function automatic logic [7:0] sat8(input logic [9:0] x);
    return (x > 10'd255) ? 8'hFF : x[7:0];
  endfunction

  // Voice selected by idx and where it goes this ACC edge.
  always_comb begin
    cur_voice = v0_q;
    cur_route = route_q[0];
    case (idx)
      2'd1:    begin cur_voice = v1_q; cur_route = route_q[1]; end
      2'd2:    begin cur_voice = v2_q; cur_route = route_q[2]; end
      default: begin cur_voice = v0_q; cur_route = route_q[0]; end
    endcase
    racc_nxt = racc;
    bacc_nxt = bacc;
    if (cur_route) racc_nxt = racc + {2'b00, cur_voice};
    else           bacc_nxt = bacc + {2'b00, cur_voice};
    mix_sum = {2'b00, result} + bacc;
  end

  // Any tick outside IDLE (including the MIX edge) is dropped and flagged.
  assign ovr_set  = sample_tick && (state != IDLE);
  assign tout_set = (state == FILT) && !filt_done && (cnt == TO_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      route_q     <= '0;
      racc        <= '0;
      bacc        <= '0;
      idx         <= '0;
      cnt         <= '0;
      result      <= '0;
      filt_start  <= 1'b0;
      filt_in     <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mix_valid <= 1'b0;

      // Set wins over a coincident clear.
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (tout_set)     timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            v0_q    <= voice0;
            v1_q    <= voice1;
            v2_q    <= voice2;
            route_q <= route;
            racc    <= '0;
            bacc    <= '0;
            idx     <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          racc <= racc_nxt;
          bacc <= bacc_nxt;
          idx  <= idx + 2'd1;
          if (idx == 2'd2) begin
            if (route_q != 3'b000) begin
              filt_start <= 1'b1;
              filt_in    <= sat8(racc_nxt);
              cnt        <= '0;
              state      <= FILT;
            end else begin
              result <= '0;
              state  <= MIX;
            end
          end
        end
        FILT: begin
          if (filt_done || tout_set) begin
            // On timeout the unfiltered input stands in for the result.
            result     <= filt_done ? filt_out : filt_in;
            filt_start <= 1'b0;
            filt_in    <= '0;
            state      <= MIX;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MIX: begin
          mix_out   <= sat8(mix_sum);
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// tb/tb_filter_ctrl.sv - directed self-checking bench for filter_ctrl
module tb_filter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic [7:0] voice0, voice1, voice2;
  logic [2:0] route;
  logic       clr_err;
  logic       filt_start;
  logic [7:0] filt_in;
  logic       filt_done;
  logic [7:0] filt_out;
  logic [7:0] mix_out;
  logic       mix_valid;
  logic       busy;
  logic       overrun;
  logic       timeout_err;

  logic       pass_mode;
  logic       done_drv;
  logic [7:0] fout_drv;

  int vec_cnt = 0;
  int err_cnt = 0;
  int mv_cnt  = 0;
  int mv0;

  always #5 clk = ~clk;

  // Pass-through filter: done tied to start, result equals input.
  assign filt_done = pass_mode ? filt_start : done_drv;
  assign filt_out  = pass_mode ? filt_in : fout_drv;

  filter_ctrl #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice0      (voice0),
    .voice1      (voice1),
    .voice2      (voice2),
    .route       (route),
    .clr_err     (clr_err),
    .filt_start  (filt_start),
    .filt_in     (filt_in),
    .filt_done   (filt_done),
    .filt_out    (filt_out),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always @(negedge clk) if (mix_valid) mv_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one frame from the current post-edge point. dly>0 (with pass_mode=0)
  // answers with fo after dly cycles of filt_start; dly=0 never answers.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [2:0] r, input int dly, input logic [7:0] fo,
                           input int e_fin, input int e_mix, input int e_starts,
                           input int e_lat, input string tag);
    int n, starts, lat, fin;
    voice0 = a; voice1 = b; voice2 = c; route = r;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    // Mid-frame input changes must be ignored.
    voice0 = 8'hAA; voice1 = 8'hBB; voice2 = 8'hCC; route = ~r;
    n = 0; starts = 0; lat = 0; fin = 0;
    while (lat == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      done_drv = 1'b0;
      if (filt_start) begin
        starts++;
        if (starts == 1) fin = int'(filt_in);
        if (dly > 0 && starts == dly) begin
          done_drv = 1'b1;
          fout_drv = fo;
        end
      end
      if (mix_valid) lat = n;
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_starts"}, starts, e_starts);
    chk({tag, "_fin"}, fin, e_fin);
    chk({tag, "_mix"}, int'(mix_out), e_mix);
    @(posedge clk); #1;
    chk({tag, "_mvpulse"}, int'(mix_valid), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; clr_err = 1'b0;
    voice0 = 8'd0; voice1 = 8'd0; voice2 = 8'd0; route = 3'd0;
    pass_mode = 1'b1; done_drv = 1'b0; fout_drv = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_filt_start", int'(filt_start), 0);
    chk("rst_filt_in", int'(filt_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_tout", int'(timeout_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through frames.
    run_frame(8'd10,  8'd20,  8'd30, 3'b011, 0, 8'd0, 30,  60,  1, 5, "partial");
    run_frame(8'd200, 8'd100, 8'd50, 3'b111, 0, 8'd0, 255, 255, 1, 5, "sat_all");
    run_frame(8'd200, 8'd100, 8'd0,  3'b001, 0, 8'd0, 200, 255, 1, 5, "sat_mix");
    run_frame(8'd50,  8'd60,  8'd70, 3'b000, 0, 8'd0, 0,   180, 0, 4, "noroute");

    // Multi-cycle filter answering after 3 cycles with its own value.
    pass_mode = 1'b0;
    run_frame(8'd5, 8'd6, 8'd7, 3'b100, 3, 8'd77, 7, 88, 3, 7, "multi");
    chk("multi_tout", int'(timeout_err), 0);

    // Timeout: filter never answers.
    run_frame(8'd40, 8'd0, 8'd0, 3'b001, 0, 8'd0, 40, 40, 16, 20, "tmo");
    chk("tmo_err", int'(timeout_err), 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("tmo_clr", int'(timeout_err), 0);
    pass_mode = 1'b1;

    // Overrun: extra tick at T+2, another on the MIX edge T+5.
    mv0 = mv_cnt;
    voice0 = 8'd1; voice1 = 8'd2; voice2 = 8'd3; route = 3'b001;
    sample_tick = 1'b1;
    @(posedge clk); #1;  // T
    sample_tick = 1'b0;
    voice0 = 8'd99; route = 3'b111;
    @(posedge clk); #1;  // T+1
    sample_tick = 1'b1;
    @(posedge clk); #1;  // T+2
    sample_tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    @(posedge clk); #1;  // T+3
    @(posedge clk); #1;  // T+4
    sample_tick = 1'b1;
    @(posedge clk); #1;  // T+5 MIX edge
    sample_tick = 1'b0;
    chk("ovr_mv", int'(mix_valid), 1);
    chk("ovr_mix", int'(mix_out), 6);
    repeat (8) @(posedge clk);
    #1;
    chk("ovr_one_mv", mv_cnt - mv0, 1);
    chk("ovr_hold", int'(mix_out), 6);
    chk("ovr_idle", int'(busy), 0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b1; clr_err = 1'b1;  // set and clear coincide
    @(posedge clk); #1;
    sample_tick = 1'b0; clr_err = 1'b0;
    chk("ovr_setwins", int'(overrun), 1);
    repeat (8) @(posedge clk);
    #1;

    // Mid-frame reset at T+2.
    mv0 = mv_cnt;
    voice0 = 8'd9; voice1 = 8'd9; voice2 = 8'd9; route = 3'b010;
    sample_tick = 1'b1;
    @(posedge clk); #1;  // T
    sample_tick = 1'b0;
    @(posedge clk); #1;  // T+1
    rst_n = 1'b0;
    @(posedge clk); #1;  // T+2 reset
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_mix_out", int'(mix_out), 0);
    chk("mrst_filt_start", int'(filt_start), 0);
    chk("mrst_overrun", int'(overrun), 0);
    sample_tick = 1'b1;  // tick on a reset edge is ignored
    @(posedge clk); #1;
    rst_n = 1'b1; sample_tick = 1'b0;
    chk("mrst_tick_ign", int'(busy), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_mv", mv_cnt - mv0, 0);
    run_frame(8'd10, 8'd20, 8'd30, 3'b011, 0, 8'd0, 30, 60, 1, 5, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/filter_ctrl.md
# filter_ctrl

Per-sample sequencer that sits between the three voice generators and the `filter` datapath. On each audio `sample_tick` it captures the three 8-bit voice samples and a route mask, and accumulates the routed voices (filter path) and the unrouted voices (bypass path). It hands the saturated routed sum to the filter over a request/done handshake, with a timeout, and mixes the filter result with the bypass sum into one saturated 8-bit output sample. The handshake lets the pass-through filter, where done is tied to start, and later multi-cycle filters share one controller.

## Interface
- `TIMEOUT`, default 16: maximum cycles `filt_start` stays high awaiting `filt_done`; legal range 1..255.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `sample_tick`  in  1  one-cycle pulse at the audio rate; starts a frame.
- `voice0`, `voice1`, `voice2`  in  8 each  unsigned voice samples.
- `route`  in  3  bit i=1 sends voice i through the filter, 0 sends it to bypass.
- `clr_err`  in  1  clears the sticky error flags.
- `filt_start`  out  1  filter request, level, held until done or timeout.
- `filt_in`  out  8  filter input sample, stable while `filt_start`=1.
- `filt_done`  in  1  filter result valid; may be high in the same cycle as `filt_start`.
- `filt_out`  in  8  filter result, sampled when `filt_done`=1.
- `mix_out`  out  8  mixed output sample, held between frames.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `busy`  out  1  high whenever state != IDLE.
- `overrun`  out  1  sticky; a tick arrived while busy.
- `timeout_err`  out  1  sticky; the filter failed to answer within `TIMEOUT`.

## Operation
- States: IDLE, ACC, FILT, MIX.
- **IDLE**
  - On `sample_tick`, latch `voice0..2` and `route` into frame registers.
  - Clear both accumulators (10-bit `racc` and `bacc`) and `idx`, then go to ACC.
- **ACC**
  - Each edge adds voice[`idx`] to `racc` if route[`idx`], otherwise to `bacc`, then increments `idx`.
  - After the `idx`=2 edge: go to FILT if the latched route != 0, else go to MIX with the filter result = 0.
- **FILT**
  - `filt_start`=1 and `filt_in`=min(`racc`,255).
  - Timeout counter (8-bit) is cleared on entry.
  - Edge with `filt_done`=1: latch `filt_out` as the result, go to MIX.
  - Edge with no done and counter = `TIMEOUT`−1: result = `filt_in`, set `timeout_err`, go to MIX.
  - Otherwise the counter increments.
- **MIX**
  - `mix_out` ← min(result + `bacc`, 255), computed at 10 bits.
  - `mix_valid` ← 1 for one cycle; go to IDLE.
- Outside FILT: `filt_start`=0 and `filt_in`=0.
- Voice and route inputs are used only at capture; changes mid-frame have no effect.
- `sample_tick` seen in any state other than IDLE, including the MIX edge, is dropped and sets `overrun`.
- `clr_err` clears `overrun` and `timeout_err`; if set and clear coincide on the same edge, set wins.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, all outputs 0, counters, accumulators and frame registers 0.
- Reset mid-frame aborts the frame with no `mix_valid`; a tick on the same edge as reset is ignored.
- Tick captured at edge T; ACC edges are T+1, T+2 and T+3.
- `filt_start` is high from after T+3 until the done or timeout edge.
- With `filt_done` arriving at edge T+3+k (k≥1), MIX executes at edge T+4+k and `mix_valid` is high during the cycle after it.
- Pass-through filter (done tied to start): k=1, so `mix_valid` follows edge T+5 and a frame takes 6 cycles.
- route=0: MIX at edge T+4 and `filt_start` never rises.
- Timeout: `filt_start` is high for exactly `TIMEOUT` cycles; MIX follows at the next edge.
- Minimum tick spacing without overrun: 6 cycles for pass-through; `TIMEOUT`+5 in the worst case.

## Test plan
- **Pass-through, partial route.** Voices 10/20/30, route=011, done tied to start. Required: `filt_in`=30, `filt_start` high for 1 cycle, `mix_out`=60, `mix_valid` after edge T+5.
- **Saturation.** Voices 200/100/50, route=111. Required: `filt_in`=255 and `mix_out`=255. Then voices 200/100/0, route=001: `filt_in`=200, `mix_out`=255 (200+100).
- **No route.** Voices 50/60/70, route=000. Required: `filt_start` never high, `mix_out`=180, `mix_valid` after edge T+4.
- **Timeout.** `filt_done` held 0, voices 40/0/0, route=001, `TIMEOUT`=16. Required: `filt_start` high for 16 cycles, `timeout_err`=1, `mix_out`=40. Then pulse `clr_err`: `timeout_err`=0.
- **Overrun.** Second tick 2 cycles after the first, then a tick on the MIX edge. Required: `overrun`=1, exactly one `mix_valid`, first frame's value unchanged. Then `clr_err` together with a new overrun tick: `overrun` stays 1.
- **Mid-frame reset.** `rst_n` low at edge T+2 (during ACC). Required: outputs 0, no `mix_valid`. A following tick completes a normal frame.
